serial_negate_ctrl: RTL and testbench
=====================================

Name: serial_negate_ctrl

Overview:
- Sequencer that negates a parallel WIDTH-bit word using an external bit-serial two's complementer.
- The complementer is the registered Mealy FSM with an active-high async reset and a one-bit input and output.
- This block latches the operand, clears the complementer, streams the operand LSB-first, reassembles the serial result into a parallel word, and flags overflow.
- Sits between a parallel requester (start/done handshake) and the serial complementer instance.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)
CNT_W, 4, bit-counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  clock; all state changes on the rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  request; sampled only in IDLE
abort  input  1  synchronous cancel; returns to IDLE, no done
din  input  WIDTH  operand; latched when start is accepted
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse; dout/ovf valid from this cycle on
dout  output  WIDTH  negated result; holds until the next done
ovf  output  1  high when din was 1 followed by WIDTH-1 zeros (result equals input)
comp_inp  output  1  serial bit to the complementer input
comp_reset  output  1  drives the complementer's active-high reset
comp_out  input  1  complementer registered output

Behaviour:
- Reset (reset=0, async):
  - state=IDLE.
  - busy=0, done=0, dout=0, ovf=0.
  - Shift register and counter = 0.
  - comp_inp=0.
  - comp_reset=1 for as long as reset=0.
- FSM states: IDLE, CLEAR, SHIFT, DRAIN, DONE.
- IDLE:
  - On start=1: latch din into shift reg `sh`, set cnt=0, compute ovf_next from din, go to CLEAR.
  - start=0: stay.
- CLEAR (1 cycle): comp_reset=1, comp_inp=0; go to SHIFT.
- SHIFT (exactly WIDTH cycles):
  - comp_inp=sh[0] combinationally.
  - Each edge: sh shifts right by one, cnt increments.
  - From the second SHIFT cycle on, capture res <= {comp_out, res[WIDTH-1:1]}.
  - After cnt reaches WIDTH-1, go to DRAIN.
- DRAIN (1 cycle): comp_inp=0; capture the final comp_out into res; go to DONE.
- Capture count: exactly WIDTH captures per word. The complementer output lags its input by one cycle, hence DRAIN.
- DONE (1 cycle): done=1; dout<=res and ovf<=ovf_next are registered on entry to DONE; go to IDLE.
- Latency: CLEAR is cycle 1 after the accepting edge; done=1 in cycle WIDTH+3 (11 for WIDTH=8).
- Throughput: a new start is accepted at the earliest in the cycle after DONE. start while busy=1 is ignored, not queued.
- abort=1 in CLEAR/SHIFT/DRAIN:
  - Next state is IDLE; done not pulsed; dout/ovf unchanged.
  - comp_reset=1 for that cycle.
  - abort in IDLE or DONE has no effect.
- Simultaneous start and abort in IDLE: start wins (abort is ignored in IDLE).
- Reset mid-operation: immediate IDLE, all outputs to reset values; the in-flight word is lost.
- Arithmetic: dout = (~din + 1) mod 2^WIDTH; din=0 gives dout=0 with ovf=0.
- comp_reset is 0 in all other states.

Test Plan:
- WIDTH=8, din=0x05, start pulse → comp_inp sequence 1,0,1,0,0,0,0,0; done at cycle 11; dout=0xFB, ovf=0, busy high cycles 1–11.
- din=0x00 → dout=0x00, ovf=0. din=0xFF → dout=0x01, ovf=0. din=0x01 → dout=0xFF.
- din=0x80 → dout=0x80, ovf=1. Follow with din=0x7F → dout=0x81, ovf=0 (ovf cleared).
- start held high continuously with din=0x03 → done every 12 cycles, dout=0xFD each time. start pulses during busy with din=0x10 → no effect on the in-flight result.
- abort in the 4th SHIFT cycle of din=0x0C → no done, dout keeps its previous value, comp_reset=1 that cycle. The next start with din=0x0C → dout=0xF4.
- reset=0 during SHIFT → busy=0, done=0, dout=0, ovf=0, comp_reset=1 immediately (async). After release, din=0x05 → dout=0xFB.

Source files
------------

// File: rtl/serial_negate_ctrl.sv
// Parallel-to-serial negation sequencer around an external bit-serial
// two's complementer: latch, clear, stream LSB-first, reassemble, flag ovf.
module serial_negate_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] din,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic             ovf,
    output logic             comp_inp,
    output logic             comp_reset,
    input  logic             comp_out
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SHIFT,
        DRAIN,
        DONE
    } state_t;

    localparam logic [WIDTH-1:0] TOP  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             ovfn_q, ovfn_d;
    logic             clr_c;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            sh_q    <= '0;
            res_q   <= '0;
            dout_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            ovfn_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            res_q   <= res_d;
            dout_q  <= dout_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            ovfn_q  <= ovfn_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sh_d     = sh_q;
        res_d    = res_q;
        dout_d   = dout_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        ovfn_d   = ovfn_q;
        comp_inp = 1'b0;
        clr_c    = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sh_d    = din;
                    cnt_d   = '0;
                    ovfn_d  = (din == TOP);
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                clr_c   = 1'b1;
                state_d = abort ? IDLE : SHIFT;
            end
            SHIFT: begin
                comp_inp = sh_q[0];
                if (abort) begin
                    clr_c   = 1'b1;
                    state_d = IDLE;
                end else begin
                    sh_d  = sh_q >> 1;
                    cnt_d = cnt_q + 1'b1;
                    // complementer output lags by one cycle: skip first edge
                    if (cnt_q != '0)
                        res_d = {comp_out, res_q[WIDTH-1:1]};
                    if (cnt_q == LAST)
                        state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (abort) begin
                    clr_c   = 1'b1;
                    state_d = IDLE;
                end else begin
                    res_d   = {comp_out, res_q[WIDTH-1:1]};
                    dout_d  = res_d;
                    ovf_d   = ovfn_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy       = (state_q != IDLE);
    assign dout       = dout_q;
    assign ovf        = ovf_q;
    assign comp_reset = ~reset | clr_c;

endmodule

// File: tb/tb_serial_negate_ctrl.sv
// Directed bench for serial_negate_ctrl with a behavioural serial
// two's complementer attached to the comp_* pins.
module tb_serial_negate_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic [7:0] din;
    logic       busy;
    logic       done;
    logic [7:0] dout;
    logic       ovf;
    logic       comp_inp;
    logic       comp_reset;
    logic       comp_out;
    logic       seen;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_negate_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .din       (din),
        .busy      (busy),
        .done      (done),
        .dout      (dout),
        .ovf       (ovf),
        .comp_inp  (comp_inp),
        .comp_reset(comp_reset),
        .comp_out  (comp_out)
    );

    // Serial complementer: copy bits up to and including the first 1, then invert.
    always_ff @(posedge clk or posedge comp_reset) begin
        if (comp_reset) begin
            seen     <= 1'b0;
            comp_out <= 1'b0;
        end else begin
            comp_out <= comp_inp ^ seen;
            seen     <= seen | comp_inp;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Pulse start with d; report done latency, serial bit stream, busy cycles.
    task automatic run_op(input logic [7:0] d, output int lat,
                          output logic [7:0] seq, output int nbusy);
        lat   = -1;
        seq   = '0;
        nbusy = 0;
        @(negedge clk);
        start = 1'b1;
        din   = d;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (n >= 2 && n <= 9) seq[n-2] = comp_inp;
            if (done) begin
                lat = n;
                break;
            end
        end
        if (lat < 0) chk("done_timeout", 0, 1);
    endtask

    typedef struct {
        logic [7:0] d;
        logic [7:0] r;
        logic       o;
    } vec_t;

    vec_t vecs[6] = '{
        '{8'h05, 8'hFB, 1'b0},
        '{8'h00, 8'h00, 1'b0},
        '{8'hFF, 8'h01, 1'b0},
        '{8'h01, 8'hFF, 1'b0},
        '{8'h80, 8'h80, 1'b1},
        '{8'h7F, 8'h81, 1'b0}
    };

    initial begin
        int         lat;
        int         nb;
        int         t0;
        int         t1;
        logic [7:0] seq;
        logic       got_done;

        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        din   = '0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dout", dout, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_comp_reset", comp_reset, 1);
        chk("rst_comp_inp", comp_inp, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].d, lat, seq, nb);
            chk($sformatf("lat_%0h", vecs[i].d), lat, 11);
            chk($sformatf("dout_%0h", vecs[i].d), dout, vecs[i].r);
            chk($sformatf("ovf_%0h", vecs[i].d), ovf, vecs[i].o);
            if (i == 0) begin
                chk("seq_05", seq, 8'h05);
                chk("busy_cycles_05", nb, 11);
                @(negedge clk);
                chk("busy_after_done", busy, 0);
                chk("dout_hold", dout, 8'hFB);
            end
        end

        // start held high: a word every 12 cycles
        @(negedge clk);
        start = 1'b1;
        din   = 8'h03;
        t0    = -1;
        t1    = -1;
        for (int n = 0; n < 40 && t1 < 0; n++) begin
            @(negedge clk);
            if (done) begin
                chk("cont_dout", dout, 8'hFD);
                if (t0 < 0) t0 = n;
                else t1 = n;
            end
        end
        chk("cont_period", t1 - t0, 12);
        start = 1'b0;
        repeat (14) @(negedge clk);

        // start pulses while busy are ignored
        start = 1'b1;
        din   = 8'h55;
        @(posedge clk);
        #1 start = 1'b0;
        din = 8'h10;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            start = (n == 3 || n == 6 || n == 10);
            if (done) begin
                lat = n;
                break;
            end
        end
        start = 1'b0;
        chk("busy_start_lat", lat, 11);
        chk("busy_start_dout", dout, 8'hAB);
        @(negedge clk);
        chk("no_queue_busy", busy, 0);

        // abort in the 4th SHIFT cycle (cycle 5)
        start = 1'b1;
        din   = 8'h0C;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        abort = 1'b1;
        #1 chk("abort_comp_reset", comp_reset, 1);
        @(posedge clk);
        #1 abort = 1'b0;
        chk("abort_busy", busy, 0);
        got_done = 1'b0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (done) got_done = 1'b1;
        end
        chk("abort_no_done", got_done, 0);
        chk("abort_dout_kept", dout, 8'hAB);
        run_op(8'h0C, lat, seq, nb);
        chk("after_abort_dout", dout, 8'hF4);
        chk("after_abort_lat", lat, 11);

        // async reset mid-SHIFT
        @(negedge clk);
        start = 1'b1;
        din   = 8'h05;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_dout", dout, 0);
        chk("mid_rst_ovf", ovf, 0);
        chk("mid_rst_comp_reset", comp_reset, 1);
        @(negedge clk);
        reset = 1'b1;
        run_op(8'h05, lat, seq, nb);
        chk("post_rst_dout", dout, 8'hFB);
        chk("post_rst_lat", lat, 11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
